// File: rtl/vp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vp_pkg
// Brief   : Shared widths and encodings for the vector processor pipeline.
// Revision: 1.0 - initial release
// ============================================================================
package vp_pkg;

  localparam int unsigned C_ADDR_W  = 8;
  localparam int unsigned C_INSTR_W = 14;
  localparam logic [C_INSTR_W-1:0] C_NOP = 14'h0000;

endpackage : vp_pkg
`default_nettype wire

// File: rtl/if_hold_buf.sv
`default_nettype none
// ============================================================================
// Module  : if_hold_buf
// Brief   : One-entry word+pc hold buffer used by the fetch stage on stalls.
// Revision: 1.0 - initial release
// ============================================================================
module if_hold_buf
  import vp_pkg::*;
#(
  parameter int unsigned ADDR_W  = C_ADDR_W,
  parameter int unsigned INSTR_W = C_INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic               i_consume,
  input  logic [INSTR_W-1:0] i_word,
  input  logic [ADDR_W-1:0]  i_pc,
  output logic [INSTR_W-1:0] o_word,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_valid
);

  localparam logic [INSTR_W-1:0] C_NOP_W = INSTR_W'(C_NOP);

  logic [INSTR_W-1:0] r_word;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_valid;

  // Clear (branch flush) wins over a simultaneous load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word  <= C_NOP_W;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_word  <= i_word;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_word  = r_word;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule : if_hold_buf
`default_nettype wire

// File: rtl/etapa_if.sv
`default_nettype none
// ============================================================================
// Module  : etapa_if
// Brief   : Instruction-fetch stage: PC, IF/ID register, stall hold buffer.
// Revision: 1.0 - initial release
// ============================================================================
module etapa_if
  import vp_pkg::*;
#(
  parameter int unsigned          ADDR_W   = C_ADDR_W,
  parameter int unsigned          INSTR_W  = C_INSTR_W,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instruccion,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               valid
);

  localparam logic [INSTR_W-1:0] C_NOP_W = INSTR_W'(C_NOP);

  logic [ADDR_W-1:0]  r_pc;
  logic               r_inflight;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc_out;
  logic               r_valid;

  logic               w_advance;
  logic               w_buf_load;
  logic               w_buf_consume;
  logic [ADDR_W-1:0]  w_pc_m1;
  logic [INSTR_W-1:0] w_buf_word;
  logic [ADDR_W-1:0]  w_buf_pc;
  logic               w_buf_valid;

  assign w_advance     = !branch_taken && !stall;
  assign w_pc_m1       = r_pc - ADDR_W'(1);
  // Only a word returning during the first stall cycle needs parking.
  assign w_buf_load    = !branch_taken && stall && r_inflight;
  assign w_buf_consume = w_advance && w_buf_valid;

  assign imem_addr = r_pc;
  assign imem_rd   = !rst && w_advance;

  if_hold_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_buf_load),
    .i_clear   (branch_taken),
    .i_consume (w_buf_consume),
    .i_word    (imem_data),
    .i_pc      (w_pc_m1),
    .o_word    (w_buf_word),
    .o_pc      (w_buf_pc),
    .o_valid   (w_buf_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_instr    <= C_NOP_W;
      r_pc_out   <= '0;
      r_valid    <= 1'b0;
    end else if (branch_taken) begin
      r_pc       <= branch_target;
      r_inflight <= 1'b0;
      r_instr    <= C_NOP_W;
      r_pc_out   <= '0;
      r_valid    <= 1'b0;
    end else if (stall) begin
      r_inflight <= 1'b0;
    end else begin
      r_pc       <= r_pc + ADDR_W'(1);
      r_inflight <= 1'b1;
      if (w_buf_valid) begin
        r_instr  <= w_buf_word;
        r_pc_out <= w_buf_pc;
        r_valid  <= 1'b1;
      end else if (r_inflight) begin
        r_instr  <= imem_data;
        r_pc_out <= w_pc_m1;
        r_valid  <= 1'b1;
      end else begin
        r_valid  <= 1'b0;
      end
    end
  end

  assign instruccion = r_instr;
  assign pc_out      = r_pc_out;
  assign valid       = r_valid;

endmodule : etapa_if
`default_nettype wire

// File: tb/tb_etapa_if.sv
`default_nettype none
// ============================================================================
// Module  : tb_etapa_if
// Brief   : Self-checking bench for etapa_if (default and RESET_PC=FE copies).
// Revision: 1.0 - initial release
// ============================================================================
module tb_etapa_if;

  typedef struct {
    logic       stall;
    logic       br;
    logic [7:0] tgt;
    logic       ev;
    logic [7:0] ep;
    logic       chk2;
    logic       ev2;
    logic [7:0] ep2;
  } vec_t;

  typedef struct {
    logic [7:0]  pc;
    logic [13:0] ins;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;

  logic [7:0]  imem_addr_a, imem_addr_b;
  logic        imem_rd_a, imem_rd_b;
  logic [13:0] imem_data_a = '0;
  logic [13:0] imem_data_b = '0;
  logic [13:0] instr_a, instr_b;
  logic [7:0]  pc_out_a, pc_out_b;
  logic        valid_a, valid_b;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  etapa_if u_dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr_a),
    .imem_rd       (imem_rd_a),
    .imem_data     (imem_data_a),
    .instruccion   (instr_a),
    .pc_out        (pc_out_a),
    .valid         (valid_a)
  );

  etapa_if #(.RESET_PC(8'hFE)) u_dut_fe (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr_b),
    .imem_rd       (imem_rd_b),
    .imem_data     (imem_data_b),
    .instruccion   (instr_b),
    .pc_out        (pc_out_b),
    .valid         (valid_b)
  );

  function automatic logic [13:0] mem_word(input logic [7:0] a);
    return {6'b0, a} ^ 14'h155;
  endfunction

  // Synchronous instruction memories, one-cycle read latency.
  always @(posedge clk) begin
    if (imem_rd_a) imem_data_a <= mem_word(imem_addr_a);
    if (imem_rd_b) imem_data_b <= mem_word(imem_addr_b);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic b, input logic [7:0] t,
                     input logic ev, input logic [7:0] ep,
                     input logic c2 = 1'b0, input logic ev2 = 1'b0,
                     input logic [7:0] ep2 = 8'h00);
    vec_t v;
    v.stall = s; v.br = b; v.tgt = t; v.ev = ev; v.ep = ep;
    v.chk2 = c2; v.ev2 = ev2; v.ep2 = ep2;
    vecs.push_back(v);
  endtask

  task automatic step(input vec_t v, input int idx);
    exp_t e;
    stall         = v.stall;
    branch_taken  = v.br;
    branch_target = v.tgt;
    #1;
    chk($sformatf("imem_rd[%0d]", idx), {31'b0, imem_rd_a}, {31'b0, !v.stall && !v.br});
    if (v.ev) begin
      e.pc  = v.ep;
      e.ins = mem_word(v.ep);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    chk($sformatf("valid[%0d]", idx), {31'b0, valid_a}, {31'b0, v.ev});
    if (valid_a === 1'b1) begin
      if (sb.size() == 0) begin
        chk($sformatf("sb_empty[%0d]", idx), 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("pc_out[%0d]", idx), {24'b0, pc_out_a}, {24'b0, e.pc});
        chk($sformatf("instr[%0d]", idx), {18'b0, instr_a}, {18'b0, e.ins});
      end
    end
    if (v.chk2) begin
      chk($sformatf("fe_valid[%0d]", idx), {31'b0, valid_b}, {31'b0, v.ev2});
      if (v.ev2) begin
        chk($sformatf("fe_pc_out[%0d]", idx), {24'b0, pc_out_b}, {24'b0, v.ep2});
        chk($sformatf("fe_instr[%0d]", idx), {18'b0, instr_b}, {18'b0, mem_word(v.ep2)});
      end
    end
  endtask

  task automatic run_vecs(input int base);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], base + i);
    vecs.delete();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"},     {31'b0, valid_a},     32'd0);
    chk({tag, "_pc_out"},    {24'b0, pc_out_a},    32'd0);
    chk({tag, "_instr"},     {18'b0, instr_a},     32'd0);
    chk({tag, "_imem_rd"},   {31'b0, imem_rd_a},   32'd0);
    chk({tag, "_imem_addr"}, {24'b0, imem_addr_a}, 32'd0);
    chk({tag, "_fe_valid"},  {31'b0, valid_b},     32'd0);
    chk({tag, "_fe_addr"},   {24'b0, imem_addr_b}, 32'h0FE);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("rst");
    rst = 1'b0;

    // Reset release, FE wrap copy checked alongside.
    add(0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00);
    add(0, 0, 8'h00, 1, 8'h00, 1, 1, 8'hFE);
    add(0, 0, 8'h00, 1, 8'h01, 1, 1, 8'hFF);
    add(0, 0, 8'h00, 1, 8'h02, 1, 1, 8'h00);
    add(0, 0, 8'h00, 1, 8'h03, 1, 1, 8'h01);
    add(0, 0, 8'h00, 1, 8'h04);
    // Three-cycle stall holding pc_out=4, then seamless release.
    for (int k = 0; k < 3; k++) add(1, 0, 8'h00, 1, 8'h04);
    for (int p = 5; p <= 10; p++) add(0, 0, 8'h00, 1, 8'(p));
    // Branch to 0x40 while pc_out=10.
    add(0, 1, 8'h40, 0, 8'h00);
    add(0, 0, 8'h00, 0, 8'h00);
    add(0, 0, 8'h00, 1, 8'h40);
    add(0, 0, 8'h00, 1, 8'h41);
    // Stall fills buffer, branch during stall flushes it.
    add(1, 0, 8'h00, 1, 8'h41);
    add(1, 1, 8'h80, 0, 8'h00);
    add(1, 0, 8'h00, 0, 8'h00);
    add(0, 0, 8'h00, 0, 8'h00);
    add(0, 0, 8'h00, 1, 8'h80);
    add(0, 0, 8'h00, 1, 8'h81);
    // Branch to top of address space; pc wraps.
    add(0, 1, 8'hFF, 0, 8'h00);
    add(0, 0, 8'h00, 0, 8'h00);
    add(0, 0, 8'h00, 1, 8'hFF);
    add(0, 0, 8'h00, 1, 8'h00);
    add(0, 0, 8'h00, 1, 8'h01);
    run_vecs(0);

    // Asynchronous reset between edges.
    #3;
    rst = 1'b1;
    #1;
    chk_reset_state("async_rst");
    @(posedge clk);
    #1;
    chk_reset_state("rst_held");
    rst = 1'b0;
    add(0, 0, 8'h00, 0, 8'h00);
    add(0, 0, 8'h00, 1, 8'h00);
    add(0, 0, 8'h00, 1, 8'h01);
    add(0, 0, 8'h00, 1, 8'h02);
    run_vecs(100);

    chk("sb_leftover", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_etapa_if
`default_nettype wire
